// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in/parallel-out deserializer.
// SIPO_PARITY_EN adds a trailing even-parity bit to every frame.
package sipo_pkg;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } sipo_state_e;

   // Counter must hold 0..WIDTH plus one spare code for the parity slot.
   function automatic int cnt_width(input int width);
      return $clog2(width + 2);
   endfunction

endpackage

// File: rtl/sipo_deser_if.sv
// Handshake/bus bundle between a serial producer and the deserializer.
interface sipo_deser_if
   import sipo_pkg::*;
#(
   parameter int WIDTH = 8
);
   localparam int CNT_W = cnt_width(WIDTH);

   logic             shift_en;
   logic             serial_in;
   logic             msb_first;
   logic             clear;
   logic             out_ready;
   logic [WIDTH-1:0] parallel_out;
   logic             out_valid;
   logic [CNT_W-1:0] bit_cnt;
   logic             overrun;
   logic             parity_err;

   modport master (
      output shift_en, serial_in, msb_first, clear, out_ready,
      input  parallel_out, out_valid, bit_cnt, overrun, parity_err
   );

   modport slave (
      input  shift_en, serial_in, msb_first, clear, out_ready,
      output parallel_out, out_valid, bit_cnt, overrun, parity_err
   );

endinterface

// File: rtl/sipo_shift_core.sv
// Shift register with direction select plus the per-frame bit counter.
module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             shift_data,
   input  logic             count_en,
   input  logic             frame_done,
   input  logic             msb_dir,
   input  logic             serial_in,
   output logic [WIDTH-1:0] sr_next,
   output logic [CNT_W-1:0] bit_cnt
);

   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      sr_d = sr_q;
      if (clear) begin
         sr_d = '0;
      end else if (shift_data) begin
         if (msb_dir) begin
            sr_d = {sr_q[WIDTH-2:0], serial_in};
         end else begin
            sr_d = {serial_in, sr_q[WIDTH-1:1]};
         end
      end
   end

   // Completion wins over counting so the next frame restarts at bit 0.
   always_comb begin
      cnt_d = cnt_q;
      if (clear || frame_done) begin
         cnt_d = '0;
      end else if (count_en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q  <= '0;
         cnt_q <= '0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
      end
   end

   assign sr_next = sr_d;
   assign bit_cnt = cnt_q;

endmodule

// File: rtl/sipo_deser.sv
// Deserializer top: frame FSM, output holding register, valid/ready handshake
// and sticky flags. SIPO_PARITY_EN adds a PAR state and the parity_err flag.
module sipo_deser
   import sipo_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   sipo_deser_if.slave  bus
);

   localparam int               CNT_W     = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_bad
      $error("sipo_deser: WIDTH %0d outside legal range", WIDTH);
   end

   sipo_state_e      state_q, state_d;
   logic             mode_q, mode_d;
   logic [WIDTH-1:0] parallel_out_q, parallel_out_d;
   logic             out_valid_q, out_valid_d;
   logic             overrun_q, overrun_d;
`ifdef SIPO_PARITY_EN
   logic             parity_err_q, parity_err_d;
`endif

   logic             accept;
   logic             shift_data;
   logic             frame_done;
   logic             msb_dir;
   logic [WIDTH-1:0] sr_next;
   logic [CNT_W-1:0] bit_cnt;

   sipo_shift_core #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (bus.clear),
      .shift_data (shift_data),
      .count_en   (accept),
      .frame_done (frame_done),
      .msb_dir    (msb_dir),
      .serial_in  (bus.serial_in),
      .sr_next    (sr_next),
      .bit_cnt    (bit_cnt)
   );

   // Bit 0 uses the live msb_first pin; later bits use the latched mode.
   always_comb begin
      accept     = bus.shift_en && !bus.clear;
      msb_dir    = (state_q == IDLE) ? bus.msb_first : mode_q;
      shift_data = accept && (state_q != PAR);
      frame_done = 1'b0;
      state_d    = state_q;
      mode_d     = mode_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               mode_d  = bus.msb_first;
            end
         end
         SHIFT: begin
            if (accept && bit_cnt == LAST_DATA) begin
`ifdef SIPO_PARITY_EN
               state_d = PAR;
`else
               state_d    = IDLE;
               frame_done = 1'b1;
`endif
            end
         end
`ifdef SIPO_PARITY_EN
         PAR: begin
            if (accept) begin
               state_d    = IDLE;
               frame_done = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      if (bus.clear) begin
         state_d = IDLE;
      end
   end

   // In PAR no shift happens, so sr_next still holds the finished data word.
   always_comb begin
      parallel_out_d = parallel_out_q;
      out_valid_d    = out_valid_q;
      overrun_d      = overrun_q;
`ifdef SIPO_PARITY_EN
      parity_err_d   = parity_err_q;
`endif
      if (bus.clear) begin
         out_valid_d  = 1'b0;
         overrun_d    = 1'b0;
`ifdef SIPO_PARITY_EN
         parity_err_d = 1'b0;
`endif
      end else if (frame_done) begin
         parallel_out_d = sr_next;
         out_valid_d    = 1'b1;
         if (out_valid_q && !bus.out_ready) begin
            overrun_d = 1'b1;
         end
`ifdef SIPO_PARITY_EN
         parity_err_d = (^sr_next) ^ bus.serial_in;
`endif
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         mode_q         <= 1'b1;
         parallel_out_q <= '0;
         out_valid_q    <= 1'b0;
         overrun_q      <= 1'b0;
`ifdef SIPO_PARITY_EN
         parity_err_q   <= 1'b0;
`endif
      end else begin
         state_q        <= state_d;
         mode_q         <= mode_d;
         parallel_out_q <= parallel_out_d;
         out_valid_q    <= out_valid_d;
         overrun_q      <= overrun_d;
`ifdef SIPO_PARITY_EN
         parity_err_q   <= parity_err_d;
`endif
      end
   end

   assign bus.parallel_out = parallel_out_q;
   assign bus.out_valid    = out_valid_q;
   assign bus.bit_cnt      = bit_cnt;
   assign bus.overrun      = overrun_q;
`ifdef SIPO_PARITY_EN
   assign bus.parity_err   = parity_err_q;
`else
   assign bus.parity_err   = 1'b0;
`endif

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, parallel word width in bits (legal range 2..64; other values are an elaboration error).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port shift_en, input, 1, qualifies serial_in; one bit accepted per edge with shift_en=1.
REQ-005 SHALL have port serial_in, input, 1, serial data bit.
REQ-006 SHALL have port msb_first, input, 1, bit order (1=MSB-first, 0=LSB-first).
REQ-007 SHALL have port clear, input, 1, synchronous abort of frame and flags.
REQ-008 SHALL have port parallel_out, output, WIDTH, last completed word (holding register).
REQ-009 SHALL have port out_valid, output, 1, completed word available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts word when out_valid=1.
REQ-011 SHALL have port bit_cnt, output, $clog2(WIDTH+2), bits accepted in current frame.
REQ-012 SHALL have port overrun, output, 1, sticky: a completed word replaced an unconsumed one.
REQ-013 SHALL have port parity_err, output, 1, parity result for the word on parallel_out.

Function
REQ-014 SHALL implement FSM states IDLE (bit_cnt=0), SHIFT (data bits), PAR (parity bit, only with SIPO_PARITY_EN).
REQ-015 SHALL latch msb_first into an internal mode register on the edge accepting bit 0 of a frame only; mid-frame changes are ignored.
REQ-016 SHALL shift MSB-first as sr<={sr[WIDTH-2:0],serial_in}, and LSB-first as sr<={serial_in,sr[WIDTH-1:1]}.
REQ-017 SHALL hold sr, bit_cnt and state unchanged on edges with shift_en=0; gaps of any length are legal.
REQ-018 SHALL, on the edge accepting the frame's last bit, load parallel_out with the completed word, set out_valid=1, reset bit_cnt to 0, and enter IDLE.
REQ-019 Latency: parallel_out/out_valid SHALL be visible in the cycle immediately after the edge accepting the last bit.
REQ-020 SHALL clear out_valid on an edge with out_valid=1 and out_ready=1 when no frame completes on that edge.
REQ-021 Frame completion with out_valid=1 and out_ready=0 SHALL overwrite parallel_out, keep out_valid=1, and set overrun.
REQ-022 Frame completion with out_valid=1 and out_ready=1 SHALL load the new word, keep out_valid=1, and leave overrun unchanged.
REQ-023 clear=1 SHALL, on that edge, zero sr, bit_cnt, out_valid, overrun and parity_err, and enter IDLE; parallel_out SHALL retain its value; clear has priority over shift_en.
REQ-024 Back-to-back frames with shift_en held at 1 SHALL lose no bits; bit 0 of the next frame SHALL be accepted on the edge after completion.

Reset
REQ-025 rst_n=0 SHALL asynchronously force: state=IDLE, sr=0, bit_cnt=0, mode=1 (MSB-first), parallel_out=0, out_valid=0, overrun=0, parity_err=0.
REQ-026 Reset assertion mid-frame SHALL discard the partial frame; the first accepted bit after deassertion SHALL be bit 0.

Configuration
REQ-027 Macro SIPO_PARITY_EN defined: each frame SHALL be WIDTH data bits plus one even-parity bit accepted in PAR; parity_err SHALL load with completion (1 if XOR of data and parity bit is 1).
REQ-028 Macro SIPO_PARITY_EN undefined: there SHALL be no PAR state, frames SHALL be WIDTH bits, and parity_err SHALL be tied 0.

Structure
REQ-029 Package sipo_pkg SHALL hold the state enum (IDLE, SHIFT, PAR) and the WIDTH legal-range constants.
REQ-030 SHALL use one sub-module, sipo_shift_core (shift register plus bit counter, direction input); the FSM, handshake and flags SHALL reside in sipo_deser.

Verification
REQ-031 Reset, then stream 1,0,1,0,1,1,0,0 MSB-first with shift_en=1 -> parallel_out=8'hAC, out_valid=1 the cycle after the 8th bit.
REQ-032 Same stream with msb_first=0 -> parallel_out=8'h35; toggle msb_first after bit 3 -> still 8'h35.
REQ-033 Stream 8'hAC with shift_en low every other cycle -> 8'hAC after 16 cycles, bit_cnt 1..7 then 0.
REQ-034 Two frames 8'hAC, 8'h5A with out_ready=0 -> parallel_out=8'h5A, out_valid=1, overrun=1; repeat with out_ready=1 at 2nd completion -> overrun=0.
REQ-035 Assert clear (then, separately, rst_n) after 4 bits, then send 8'hF0 -> parallel_out=8'hF0, overrun=0.
REQ-036 With SIPO_PARITY_EN: 8'hAC + parity 0 -> parity_err=0; 8'hAC + parity 1 -> parity_err=1; 9 bits per frame.
